// File: rtl/and_in_pkg.sv
// Shared definitions for the AND-gate input debouncer: FSM encoding and
// default stable-cycle counts for simulation and board builds.
package and_in_pkg;

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_ARM_H = 2'd1,
        ST_HIGH  = 2'd2,
        ST_ARM_L = 2'd3
    } state_t;

    localparam int STABLE_CYCLES_SIM   = 16;
    localparam int STABLE_CYCLES_BOARD = 500000;

    // Debounced level implied by a state: HIGH and ARM_L both present 1.
    function automatic logic level_of(input state_t s);
        return (s == ST_HIGH) || (s == ST_ARM_L);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, 4-state FSM and run-length counter.
// Optional edge pulses (rise/fall) are built when DEBOUNCE_PULSE_EN is defined.
module debounce_ch
    import and_in_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_SIM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
`ifdef DEBOUNCE_PULSE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_reg;
    logic             s2_reg;
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            state_reg <= ST_LOW;
            cnt_reg   <= '0;
        end else begin
            s1_reg    <= raw;
            s2_reg    <= s1_reg;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The edge that moves an idle state into ARM_* is itself the first
    // counting edge, so the count starts at 1 there.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_LOW: begin
                cnt_next = '0;
                if (s2_reg) begin
                    state_next = ST_ARM_H;
                    cnt_next   = CNT_ONE;
                end
            end
            ST_ARM_H: begin
                if (!s2_reg) begin
                    state_next = ST_LOW;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_HIGH: begin
                cnt_next = '0;
                if (!s2_reg) begin
                    state_next = ST_ARM_L;
                    cnt_next   = CNT_ONE;
                end
            end
            ST_ARM_L: begin
                if (s2_reg) begin
                    state_next = ST_HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_LOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    assign level = level_of(state_reg);

`ifdef DEBOUNCE_PULSE_EN
    // Pulses are registered from the upcoming level against the current one,
    // so they rise on the same edge as the level change and last one cycle.
    logic level_next;
    logic rise_reg;
    logic fall_reg;

    assign level_next = level_of(state_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            rise_reg <= level_next & ~level;
            fall_reg <= ~level_next & level;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;
`endif

endmodule

// File: rtl/and_in_debounce.sv
// Two independent debounce channels feeding the AND-gate inputs a0/a1.
// Define DEBOUNCE_PULSE_EN to add the *_rise/*_fall pulse ports.
module and_in_debounce
    import and_in_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_SIM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw0_raw,
    input  logic sw1_raw,
    output logic a0,
    output logic a1
`ifdef DEBOUNCE_PULSE_EN
    ,
    output logic a0_rise,
    output logic a1_rise,
    output logic a0_fall,
    output logic a1_fall
`endif
);

    debounce_ch #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch0 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw0_raw),
        .level (a0)
`ifdef DEBOUNCE_PULSE_EN
        ,
        .rise  (a0_rise),
        .fall  (a0_fall)
`endif
    );

    debounce_ch #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch1 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw1_raw),
        .level (a1)
`ifdef DEBOUNCE_PULSE_EN
        ,
        .rise  (a1_rise),
        .fall  (a1_fall)
`endif
    );

endmodule
